// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - multi-channel binary-to-BCD seven-segment scan driver
// Optional build macro: SSD_LZ_BLANK_EN enables per-channel leading-zero blanking.
module ssd_scan_driver #(
    parameter int NUM_CH    = 2,
    parameter int CH_DIGITS = 4,
    parameter int BIN_W     = 16,
    parameter int SCAN_BITS = 18
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH*BIN_W-1:0]     value,
    input  logic                        load,
    output logic                        busy,
    output logic [NUM_CH-1:0]           overflow,
    output logic [NUM_CH*CH_DIGITS-1:0] anode,
    output logic [6:0]                  ssdOut
);
    localparam int TOTAL   = NUM_CH * CH_DIGITS;
    localparam int BCD_MIN = (BIN_W * 30103) / 100000 + 1;
    localparam int BCD_N   = (BCD_MIN > CH_DIGITS) ? BCD_MIN : CH_DIGITS;
    localparam int BCD_TW  = 4 * BCD_N;
    localparam int DISP_W  = 4 * TOTAL;
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DIG_W   = (CH_DIGITS > 1) ? $clog2(CH_DIGITS) : 1;
    localparam int K_W     = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int BIT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [63:0] max_shown();
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < CH_DIGITS; i++) r = r * 64'd10;
        return r - 64'd1;
    endfunction

    localparam logic [63:0] LIMIT = max_shown();

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return SEG_BLANK;
        endcase
    endfunction

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t                  state_q, state_d;
    logic [NUM_CH*BIN_W-1:0] cap;
    logic [BIN_W-1:0]        bin_sr, cap_ch, cur_bin, next_bin;
    logic [BCD_TW-1:0]       bcd, cur_bcd, adj, next_bcd;
    logic [CH_W-1:0]         ch_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [DISP_W-1:0]       pend_bcd, merged_bcd, disp_bcd;
    logic [NUM_CH-1:0]       pend_ovf, merged_ovf;
    logic                    ch_done, last_ch;

    assign busy = (state_q == S_CONV);

    // One double-dabble step; the first step of each channel seeds from the captured value.
    always_comb begin
        state_d  = state_q;
        cap_ch   = cap[int'(ch_cnt)*BIN_W +: BIN_W];
        cur_bin  = (bit_cnt == '0) ? cap_ch : bin_sr;
        cur_bcd  = (bit_cnt == '0) ? '0 : bcd;
        adj      = cur_bcd;
        for (int i = 0; i < BCD_N; i++) begin
            if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
        end
        next_bcd = (adj << 1) | BCD_TW'(cur_bin[BIN_W-1]);
        next_bin = cur_bin << 1;
        ch_done  = (bit_cnt == BIT_W'(BIN_W - 1));
        last_ch  = (ch_cnt == CH_W'(NUM_CH - 1));
        merged_bcd = pend_bcd;
        merged_bcd[int'(ch_cnt)*CH_DIGITS*4 +: CH_DIGITS*4] = next_bcd[CH_DIGITS*4-1:0];
        merged_ovf = pend_ovf;
        merged_ovf[ch_cnt] = (64'(cap_ch) > LIMIT);
        case (state_q)
            S_IDLE:  if (load) state_d = S_CONV;
            S_CONV:  if (ch_done && last_ch) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Results collect in pend_* and reach the display only when the last channel finishes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap      <= '0;
            bin_sr   <= '0;
            bcd      <= '0;
            ch_cnt   <= '0;
            bit_cnt  <= '0;
            pend_bcd <= '0;
            pend_ovf <= '0;
            disp_bcd <= '0;
            overflow <= '0;
        end else if (state_q == S_IDLE) begin
            if (load) begin
                cap     <= value;
                ch_cnt  <= '0;
                bit_cnt <= '0;
            end
        end else begin
            bin_sr <= next_bin;
            bcd    <= next_bcd;
            if (ch_done) begin
                bit_cnt  <= '0;
                ch_cnt   <= last_ch ? '0 : ch_cnt + 1'b1;
                pend_bcd <= merged_bcd;
                pend_ovf <= merged_ovf;
                if (last_ch) begin
                    disp_bcd <= merged_bcd;
                    overflow <= merged_ovf;
                end
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    logic [SCAN_BITS-1:0] scan_cnt;
    logic [K_W-1:0]       k;
    logic [CH_W-1:0]      sel_ch;
    logic [DIG_W-1:0]     sel_dig;
    logic [3:0]           cur_digit;
    logic [TOTAL-1:0]     anode_d;
    logic [6:0]           seg_d;
    logic                 blank;
`ifdef SSD_LZ_BLANK_EN
    logic                 lead_nz;
`endif

    // k is the flat digit index (channel*CH_DIGITS + digit), counting down from the top.
    always_comb begin
        cur_digit = disp_bcd[int'(k)*4 +: 4];
        anode_d   = ~(TOTAL'(1) << k);
        blank     = 1'b0;
`ifdef SSD_LZ_BLANK_EN
        lead_nz = 1'b0;
        for (int j = 0; j < CH_DIGITS; j++) begin
            if (j >= int'(sel_dig) && disp_bcd[(int'(sel_ch)*CH_DIGITS + j)*4 +: 4] != 4'd0)
                lead_nz = 1'b1;
        end
        blank = !lead_nz && (sel_dig != '0);
`endif
        if (overflow[sel_ch]) seg_d = SEG_DASH;
        else if (blank)       seg_d = SEG_BLANK;
        else                  seg_d = seg7(cur_digit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            k        <= K_W'(TOTAL - 1);
            sel_ch   <= CH_W'(NUM_CH - 1);
            sel_dig  <= DIG_W'(CH_DIGITS - 1);
            anode    <= '1;
            ssdOut   <= SEG_BLANK;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
            anode    <= anode_d;
            ssdOut   <= seg_d;
            if (scan_cnt == '1) begin
                k <= (k == '0) ? K_W'(TOTAL - 1) : k - 1'b1;
                if (sel_dig == '0) begin
                    sel_dig <= DIG_W'(CH_DIGITS - 1);
                    sel_ch  <= (sel_ch == '0) ? CH_W'(NUM_CH - 1) : sel_ch - 1'b1;
                end else begin
                    sel_dig <= sel_dig - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - randomized self-checking bench for ssd_scan_driver
module tb_ssd_scan_driver;
    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        load    = 1'b0;
    logic [31:0] value_a = '0;
    logic [47:0] value_b = '0;
    logic [15:0] value_c = '0;
    logic        busy_a, busy_b, busy_c;
    logic [1:0]  ovf_a;
    logic [2:0]  ovf_b;
    logic [0:0]  ovf_c;
    logic [7:0]  an_a;
    logic [5:0]  an_b;
    logic [4:0]  an_c;
    logic [6:0]  seg_a, seg_b, seg_c;

    int errors = 0;
    int checks = 0;
    int ncyc   = 0;
    int unsigned m_val [3][3];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) ncyc <= 0;
        else       ncyc <= ncyc + 1;
    end

    ssd_scan_driver #(.NUM_CH(2), .CH_DIGITS(4), .BIN_W(16), .SCAN_BITS(2)) dut_a (
        .clk(clk), .reset(reset), .value(value_a), .load(load),
        .busy(busy_a), .overflow(ovf_a), .anode(an_a), .ssdOut(seg_a));
    ssd_scan_driver #(.NUM_CH(3), .CH_DIGITS(2), .BIN_W(16), .SCAN_BITS(2)) dut_b (
        .clk(clk), .reset(reset), .value(value_b), .load(load),
        .busy(busy_b), .overflow(ovf_b), .anode(an_b), .ssdOut(seg_b));
    ssd_scan_driver #(.NUM_CH(1), .CH_DIGITS(5), .BIN_W(16), .SCAN_BITS(2)) dut_c (
        .clk(clk), .reset(reset), .value(value_c), .load(load),
        .busy(busy_c), .overflow(ovf_c), .anode(an_c), .ssdOut(seg_c));

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nch_of(input int di);
        case (di) 0: return 2; 1: return 3; default: return 1; endcase
    endfunction

    function automatic int cd_of(input int di);
        case (di) 0: return 4; 1: return 2; default: return 5; endcase
    endfunction

    function automatic int unsigned pow10(input int n);
        int unsigned r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] digit_seg(input int unsigned n);
        case (n)
            0: return 7'b0000001; 1: return 7'b1001111; 2: return 7'b0010010;
            3: return 7'b0000110; 4: return 7'b1001100; 5: return 7'b0100100;
            6: return 7'b0100000; 7: return 7'b0001111; 8: return 7'b0000000;
            default: return 7'b0000100;
        endcase
    endfunction

    // Position p: channel counted from the top, digit counted from the MSD.
    function automatic logic [6:0] exp_seg(input int di, input int pos);
        int nch = nch_of(di);
        int cd  = cd_of(di);
        int c   = nch - 1 - pos / cd;
        int d   = cd - 1 - pos % cd;
        int unsigned v = m_val[di][c];
        if (v > pow10(cd) - 1) return 7'b1111110;
`ifdef SSD_LZ_BLANK_EN
        if (d > 0 && v < pow10(d)) return 7'b1111111;
`endif
        return digit_seg((v / pow10(d)) % 10);
    endfunction

    task automatic get_obs(input int di, output logic [31:0] an, output logic [31:0] seg,
                           output logic [31:0] bsy, output logic [31:0] ovf);
        case (di)
            0:       begin an = 32'(an_a); seg = 32'(seg_a); bsy = 32'(busy_a); ovf = 32'(ovf_a); end
            1:       begin an = 32'(an_b); seg = 32'(seg_b); bsy = 32'(busy_b); ovf = 32'(ovf_b); end
            default: begin an = 32'(an_c); seg = 32'(seg_c); bsy = 32'(busy_c); ovf = 32'(ovf_c); end
        endcase
    endtask

    task automatic check_disp(input int di);
        logic [31:0] an, seg, bsy, ovf;
        int total, pos;
        total = nch_of(di) * cd_of(di);
        pos   = ((ncyc - 1) / 4) % total;
        get_obs(di, an, seg, bsy, ovf);
        expect_eq($sformatf("d%0d_anode_p%0d", di, pos), an,
                  32'(((1 << total) - 1) & ~(1 << (total - 1 - pos))));
        expect_eq($sformatf("d%0d_seg_p%0d", di, pos), seg, 32'(exp_seg(di, pos)));
    endtask

    task automatic check_ovf(input int di);
        logic [31:0] an, seg, bsy, ovf, e;
        get_obs(di, an, seg, bsy, ovf);
        e = '0;
        for (int c = 0; c < nch_of(di); c++)
            if (m_val[di][c] > pow10(cd_of(di)) - 1) e[c] = 1'b1;
        expect_eq($sformatf("d%0d_overflow", di), ovf, e);
    endtask

    task automatic check_reset_state();
        logic [31:0] an, seg, bsy, ovf;
        for (int di = 0; di < 3; di++) begin
            get_obs(di, an, seg, bsy, ovf);
            expect_eq($sformatf("d%0d_rst_anode", di), an, 32'((1 << (nch_of(di) * cd_of(di))) - 1));
            expect_eq($sformatf("d%0d_rst_seg", di), seg, 32'h7f);
            expect_eq($sformatf("d%0d_rst_busy", di), bsy, 0);
            expect_eq($sformatf("d%0d_rst_ovf", di), ovf, 0);
        end
    endtask

    task automatic check_display_all(input int n);
        for (int di = 0; di < 3; di++) check_ovf(di);
        for (int i = 0; i < n; i++) begin
            for (int di = 0; di < 3; di++) check_disp(di);
            @(negedge clk);
        end
    endtask

    // Old digits must stay on screen while busy; a second load at second_at must be ignored.
    task automatic do_conv(input int a1, input int a0, input int b2, input int b1, input int b0,
                           input int c0, input int second_at, input int reset_at);
        int cnt [3];
        int cyc;
        cnt = '{0, 0, 0};
        cyc = 0;
        value_a = {a1[15:0], a0[15:0]};
        value_b = {b2[15:0], b1[15:0], b0[15:0]};
        value_c = c0[15:0];
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        while (busy_a || busy_b || busy_c) begin
            if (cyc >= 200) break;
            if (busy_a) begin cnt[0]++; check_disp(0); end
            if (busy_b) begin cnt[1]++; check_disp(1); end
            if (busy_c) begin cnt[2]++; check_disp(2); end
            if (reset_at > 0 && cnt[0] == reset_at) begin
                reset = 1'b1;
                return;
            end
            if (cyc == second_at) begin
                load = 1'b1;
                value_a = ~value_a;
                value_b = ~value_b;
                value_c = ~value_c;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        load = 1'b0;
        expect_eq("busy_timeout", 32'(busy_a | busy_b | busy_c), 0);
        expect_eq("busy_len_a", cnt[0], 32);
        expect_eq("busy_len_b", cnt[1], 48);
        expect_eq("busy_len_c", cnt[2], 16);
        m_val[0][1] = a1; m_val[0][0] = a0;
        m_val[1][2] = b2; m_val[1][1] = b1; m_val[1][0] = b0;
        m_val[2][0] = c0;
        repeat (2) @(negedge clk);
        check_display_all(40);
    endtask

    initial begin
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) m_val[i][j] = 0;

        repeat (3) @(negedge clk);
        check_reset_state();
        load = 1'b1;
        @(negedge clk);
        check_reset_state();
        load = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        expect_eq("load_ignored_in_reset", 32'(busy_a | busy_b | busy_c), 0);
        check_display_all(40);

        do_conv(1234, 56, 12, 34, 56, 65535, -1, 0);
        do_conv(4321, 10000, 99, 100, 0, 0, -1, 0);
        do_conv(9876, 5, 7, 8, 9, 100, 5, 0);
        for (int it = 0; it < 4; it++)
            do_conv(int'($urandom_range(0, 12000)), int'($urandom_range(0, 12000)),
                    int'($urandom_range(0, 150)), int'($urandom_range(0, 150)),
                    int'($urandom_range(0, 150)), int'($urandom_range(0, 65535)), -1, 0);

        do_conv(8888, 20000, 55, 66, 777, 4242, -1, 10);
        @(negedge clk);
        check_reset_state();
        load = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_reset_state();
        end
        load = 1'b0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) m_val[i][j] = 0;
        reset = 1'b0;
        @(negedge clk);
        expect_eq("busy_after_abort", 32'(busy_a | busy_b | busy_c), 0);
        check_display_all(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
